// File: rtl/rom_ctrl_check_seq_pkg.sv
// Shared types and constants for the power-up ROM integrity check sequencer.
package rom_ctrl_check_pkg;

   localparam int unsigned DefRomDepth    = 16;
   localparam int unsigned DefRomTopCount = 2;
   localparam int unsigned DefDW          = 32;

   function automatic int unsigned vbits(int unsigned n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

   function automatic int unsigned non_top_count(int unsigned depth, int unsigned top_count);
      return depth - top_count;
   endfunction

   localparam int unsigned RomNonTopCount = non_top_count(DefRomDepth, DefRomTopCount);

   typedef logic [DefRomTopCount*DefDW-1:0] rom_digest_t;

   // Every pair of codes differs in at least 3 bits, so a single upset never
   // lands on another legal state.
   typedef enum logic [5:0] {
      Idle     = 6'b001011,
      ReadLow  = 6'b010101,
      ReadHigh = 6'b011110,
      WaitKmac = 6'b100110,
      Compare  = 6'b101101,
      Done     = 6'b110011,
      Invalid  = 6'b111000
   } rom_check_state_e;

endpackage

// File: rtl/rom_ctrl_check_seq_if.sv
// ROM read port and KMAC app port seen by the check sequencer.
interface rom_ctrl_check_seq_if
   import rom_ctrl_check_pkg::*;
#(
   parameter int unsigned DW      = DefDW,
   parameter int unsigned AW      = vbits(DefRomDepth),
   parameter int unsigned DigestW = DefRomTopCount * DefDW
);

   logic               rom_req_o;
   logic [AW-1:0]      rom_addr_o;
   logic [DW-1:0]      rom_rdata_i;
   logic               kmac_valid_o;
   logic [DW-1:0]      kmac_data_o;
   logic               kmac_last_o;
   logic               kmac_ready_i;
   logic               kmac_done_i;
   logic [DigestW-1:0] kmac_digest_i;

   modport master (
      output rom_req_o, rom_addr_o, kmac_valid_o, kmac_data_o, kmac_last_o,
      input  rom_rdata_i, kmac_ready_i, kmac_done_i, kmac_digest_i
   );

   modport slave (
      input  rom_req_o, rom_addr_o, kmac_valid_o, kmac_data_o, kmac_last_o,
      output rom_rdata_i, kmac_ready_i, kmac_done_i, kmac_digest_i
   );

endinterface

// File: rtl/rom_ctrl_check_seq_digest_cmp.sv
// Expected-digest register, KMAC digest latch and registered match flag.
module rom_ctrl_digest_cmp #(
   parameter int unsigned RomTopCount = 2,
   parameter int unsigned DW          = 32,
   parameter int unsigned IdxW        = 4
) (
   input  logic                      clk_i,
   input  logic                      rst_ni,
   input  logic                      exp_we_i,
   input  logic [IdxW-1:0]           exp_idx_i,
   input  logic [DW-1:0]             exp_wdata_i,
   input  logic                      dig_latch_i,
   input  logic [RomTopCount*DW-1:0] dig_i,
   input  logic                      cmp_en_i,
   input  logic                      set_match_i,
   output logic                      match_o
);

   logic [RomTopCount*DW-1:0] exp_q, exp_d;
   logic [RomTopCount*DW-1:0] dig_q, dig_d;
   logic                      match_q, match_d;

   always_comb begin
      exp_d = exp_q;
      for (int unsigned i = 0; i < RomTopCount; i++) begin
         if (exp_we_i && (exp_idx_i == IdxW'(i))) exp_d[i*DW +: DW] = exp_wdata_i;
      end
      dig_d   = dig_latch_i ? dig_i : dig_q;
      match_d = match_q;
      if (set_match_i)   match_d = 1'b1;
      else if (cmp_en_i) match_d = (dig_q == exp_q);
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         exp_q   <= '0;
         dig_q   <= '0;
         match_q <= 1'b0;
      end else begin
         exp_q   <= exp_d;
         dig_q   <= dig_d;
         match_q <= match_d;
      end
   end

   assign match_o = match_q;

endmodule

// File: rtl/rom_ctrl_check_seq.sv
// Power-up ROM integrity check sequencer: ROM -> KMAC, then digest compare and bus handover.
// Optional macro ROM_CTRL_CHECK_SEQ_BYPASS_EN adds bypass_i to skip the check.
module rom_ctrl_check_seq
   import rom_ctrl_check_pkg::*;
#(
   parameter int unsigned RomDepth    = DefRomDepth,
   parameter int unsigned RomTopCount = DefRomTopCount,
   parameter int unsigned DW          = DefDW
) (
   input  logic clk_i,
   input  logic rst_ni,
`ifdef ROM_CTRL_CHECK_SEQ_BYPASS_EN
   input  logic bypass_i,
`endif
   rom_ctrl_check_seq_if.master bus,
   output logic sel_bus_o,
   output logic check_done_o,
   output logic check_good_o,
   output logic alert_o
);

   localparam int unsigned AW          = vbits(RomDepth);
   localparam int unsigned NonTopCount = non_top_count(RomDepth, RomTopCount);
   localparam logic [AW-1:0] LastLowAddr = AW'(NonTopCount - 1);
   localparam logic [AW-1:0] LastAddr    = AW'(RomDepth - 1);

   rom_check_state_e state_q, state_d;
   logic [AW-1:0]    addr_q, addr_d;
   logic             req_q, req_d;
   logic             vld_q, vld_d;
   logic             exp_we, dig_latch, cmp_en, set_match, match;
   logic             last_store, in_read, kmac_valid;

   // vld_q marks "ROM data for addr_q is on rom_rdata_i"; in ReadLow it is the KMAC valid.
   assign last_store = vld_q && (addr_q == LastAddr);

   always_comb begin
      state_d   = state_q;
      addr_d    = addr_q;
      req_d     = 1'b0;
      vld_d     = 1'b0;
      exp_we    = 1'b0;
      dig_latch = 1'b0;
      cmp_en    = 1'b0;
      set_match = 1'b0;
      case (state_q)
         Idle: begin
`ifdef ROM_CTRL_CHECK_SEQ_BYPASS_EN
            if (bypass_i) begin
               state_d   = Done;
               set_match = 1'b1;
            end else begin
               state_d = ReadLow;
               addr_d  = '0;
               req_d   = 1'b1;
            end
`else
            state_d = ReadLow;
            addr_d  = '0;
            req_d   = 1'b1;
`endif
         end
         ReadLow: begin
            if (bus.kmac_done_i) begin
               state_d = Invalid;
            end else if (req_q) begin
               vld_d = 1'b1;
            end else if (vld_q) begin
               if (bus.kmac_ready_i) begin
                  req_d  = 1'b1;
                  addr_d = addr_q + AW'(1);
                  if (addr_q == LastLowAddr) state_d = ReadHigh;
               end else begin
                  vld_d = 1'b1;
               end
            end
         end
         ReadHigh: begin
            // A digest arriving with the final top word is legal; any earlier one is not.
            if (bus.kmac_done_i && !last_store) begin
               state_d = Invalid;
            end else if (req_q) begin
               vld_d = 1'b1;
            end else if (vld_q) begin
               exp_we = 1'b1;
               if (addr_q == LastAddr) begin
                  if (bus.kmac_done_i) begin
                     dig_latch = 1'b1;
                     state_d   = Compare;
                  end else begin
                     state_d = WaitKmac;
                  end
               end else begin
                  addr_d = addr_q + AW'(1);
                  req_d  = 1'b1;
               end
            end
         end
         WaitKmac: begin
            if (bus.kmac_done_i) begin
               dig_latch = 1'b1;
               state_d   = Compare;
            end
         end
         Compare: begin
            cmp_en  = 1'b1;
            state_d = Done;
         end
         Done:    state_d = Done;
         Invalid: state_d = Invalid;
         default: state_d = Invalid;
      endcase
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q <= Idle;
         addr_q  <= '0;
         req_q   <= 1'b0;
         vld_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         addr_q  <= addr_d;
         req_q   <= req_d;
         vld_q   <= vld_d;
      end
   end

   rom_ctrl_digest_cmp #(
      .RomTopCount (RomTopCount),
      .DW          (DW),
      .IdxW        (AW)
   ) u_digest_cmp (
      .clk_i       (clk_i),
      .rst_ni      (rst_ni),
      .exp_we_i    (exp_we),
      .exp_idx_i   (addr_q - AW'(NonTopCount)),
      .exp_wdata_i (bus.rom_rdata_i),
      .dig_latch_i (dig_latch),
      .dig_i       (bus.kmac_digest_i),
      .cmp_en_i    (cmp_en),
      .set_match_i (set_match),
      .match_o     (match)
   );

   assign in_read    = (state_q == ReadLow) || (state_q == ReadHigh);
   assign kmac_valid = vld_q && (state_q == ReadLow);

   assign bus.rom_req_o    = req_q && in_read;
   assign bus.rom_addr_o   = addr_q;
   assign bus.kmac_valid_o = kmac_valid;
   assign bus.kmac_data_o  = kmac_valid ? bus.rom_rdata_i : '0;
   assign bus.kmac_last_o  = kmac_valid && (addr_q == LastLowAddr);

   assign sel_bus_o    = (state_q == Done);
   assign check_done_o = (state_q == Done) || (state_q == Invalid);
   assign check_good_o = (state_q == Done) && match;
   assign alert_o      = (state_q == Invalid) || ((state_q == Done) && !match);

endmodule

// File: tb/tb_rom_ctrl_check_seq.sv
// Table-driven bench for rom_ctrl_check_seq with a behavioural ROM and KMAC responder.
module tb_rom_ctrl_check_seq;
   import rom_ctrl_check_pkg::*;

   localparam int unsigned RomDepth    = 16;
   localparam int unsigned RomTopCount = 2;
   localparam int unsigned DW          = 32;
   localparam int unsigned AW          = vbits(RomDepth);
   localparam int          Budget      = 200;
   localparam logic [DW-1:0] StallWord = 32'h1003;
   localparam logic [DW-1:0] LastWord  = 32'h1000 + RomNonTopCount - 1;
   localparam logic [63:0] GoodDig = {32'h100F, 32'h100E};
   localparam logic [63:0] BadDig  = {32'h100F, 32'h100F};
   localparam logic [63:0] MsbDig  = {32'h900F, 32'h100E};

   typedef struct {
      logic [63:0] digest;
      int          done_delay;
      int          stall_len;
      int          early_addr;
      int          exp_words;
      int          exp_last;
      int          exp_reqs;
      int          exp_cyc;
      logic        exp_done;
      logic        exp_good;
      logic        exp_alert;
      logic        exp_sel;
   } vec_t;

   logic clk_i  = 1'b0;
   logic rst_ni = 1'b0;
   logic sel_bus_o, check_done_o, check_good_o, alert_o;
`ifdef ROM_CTRL_CHECK_SEQ_BYPASS_EN
   logic bypass_i = 1'b0;
`endif
   int checks   = 0;
   int failures = 0;
   logic [DW-1:0] rom_rdata = '0;

   always #5 clk_i = ~clk_i;

   rom_ctrl_check_seq_if #(.DW(DW), .AW(AW), .DigestW(RomTopCount*DW)) bus ();

   rom_ctrl_check_seq #(
      .RomDepth    (RomDepth),
      .RomTopCount (RomTopCount),
      .DW          (DW)
   ) dut (
      .clk_i        (clk_i),
      .rst_ni       (rst_ni),
`ifdef ROM_CTRL_CHECK_SEQ_BYPASS_EN
      .bypass_i     (bypass_i),
`endif
      .bus          (bus),
      .sel_bus_o    (sel_bus_o),
      .check_done_o (check_done_o),
      .check_good_o (check_good_o),
      .alert_o      (alert_o)
   );

   // ROM word n holds 0x1000+n; data appears the cycle after the request and is held.
   always @(posedge clk_i) begin
      if (bus.rom_req_o) rom_rdata <= 32'h1000 + 32'(bus.rom_addr_o);
   end
   assign bus.rom_rdata_i = rom_rdata;

   initial begin
      #200us;
      $display("FAIL watchdog act=timeout exp=finish");
      $fatal(1, "watchdog");
   end

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s act=0x%0h exp=0x%0h", name, act, exp);
      end
   endtask

   function automatic logic [63:0] outs();
      return 64'({bus.rom_req_o, bus.rom_addr_o, bus.kmac_valid_o, bus.kmac_data_o,
                  bus.kmac_last_o, sel_bus_o, check_done_o, check_good_o, alert_o});
   endfunction

   task automatic do_reset(input bit chk, input string tag);
      rst_ni           = 1'b0;
      bus.kmac_ready_i = 1'b0;
      bus.kmac_done_i  = 1'b0;
      repeat (2) @(negedge clk_i);
      if (chk) check(tag, outs(), 64'd0);
   endtask

   // Cycle count is inclusive: the cycle in which rst_ni rises is cycle 1.
   task automatic run_vec(input int idx, input vec_t v);
      int t_hs = -1, t_done = -1;
      int n_words = 0, n_last = 0, n_reqs = 0, n_bad_data = 0, n_bad_req = 0;
      int stall_n = 0, stall_bad = 0, last_bad = 0;
      bit early_sent = 1'b0;
      do_reset(1'b0, "");
      bus.kmac_digest_i = v.digest;
      rst_ni = 1'b1;
      for (int t = 0; t < Budget; t++) begin
         if (bus.rom_req_o) begin
            if (bus.rom_addr_o != AW'(n_reqs)) n_bad_req++;
            n_reqs++;
         end
         bus.kmac_done_i = 1'b0;
         if (t_hs >= 0 && t == t_hs + v.done_delay + 1) bus.kmac_done_i = 1'b1;
         if (v.early_addr >= 0 && !early_sent && bus.rom_req_o &&
             int'(bus.rom_addr_o) == v.early_addr) begin
            bus.kmac_done_i = 1'b1;
            early_sent      = 1'b1;
         end
         bus.kmac_ready_i = 1'b1;
         if (bus.kmac_valid_o && bus.kmac_data_o == StallWord && stall_n < v.stall_len) begin
            bus.kmac_ready_i = 1'b0;
            stall_n++;
            if (bus.rom_req_o) stall_bad++;
         end
         if (bus.kmac_last_o && !(bus.kmac_valid_o && bus.kmac_data_o == LastWord)) last_bad++;
         if (bus.kmac_valid_o && bus.kmac_ready_i) begin
            if (bus.kmac_data_o != 32'h1000 + 32'(n_words)) n_bad_data++;
            n_words++;
            if (bus.kmac_last_o) begin
               n_last++;
               t_hs = t;
            end
         end
         if (check_done_o && t_done < 0) t_done = t;
         if (t_done >= 0 && t == t_done + 3) break;
         @(negedge clk_i);
      end
      bus.kmac_done_i = 1'b0;
      check($sformatf("v%0d_words", idx),     n_words,    v.exp_words);
      check($sformatf("v%0d_data", idx),      n_bad_data, 0);
      check($sformatf("v%0d_last_cnt", idx),  n_last,     v.exp_last);
      check($sformatf("v%0d_last_only", idx), last_bad,   0);
      check($sformatf("v%0d_reqs", idx),      n_reqs,     v.exp_reqs);
      check($sformatf("v%0d_req_order", idx), n_bad_req,  0);
      check($sformatf("v%0d_stall_len", idx), stall_n,    v.stall_len);
      check($sformatf("v%0d_stall_req", idx), stall_bad,  0);
      check($sformatf("v%0d_cycles", idx),    t_done + 1, v.exp_cyc);
      check($sformatf("v%0d_flags", idx), {check_done_o, check_good_o, alert_o, sel_bus_o},
            {v.exp_done, v.exp_good, v.exp_alert, v.exp_sel});
      check($sformatf("v%0d_quiet", idx), {bus.rom_req_o, bus.kmac_valid_o}, 2'b00);
   endtask

   initial begin : main
      vec_t vecs [6];
      bit   hit;
      int   t_done, bad;

      // digest, done_delay, stall_len, early_addr, words, last, reqs, cycles, done, good, alert, sel
      vecs[0] = '{GoodDig, 3, 0, -1, 14, 1, 16, 35, 1'b1, 1'b1, 1'b0, 1'b1};
      vecs[1] = '{BadDig,  3, 0, -1, 14, 1, 16, 35, 1'b1, 1'b0, 1'b1, 1'b1};
      vecs[2] = '{MsbDig,  6, 0, -1, 14, 1, 16, 38, 1'b1, 1'b0, 1'b1, 1'b1};
      vecs[3] = '{GoodDig, 6, 0, -1, 14, 1, 16, 38, 1'b1, 1'b1, 1'b0, 1'b1};
      vecs[4] = '{GoodDig, 3, 5, -1, 14, 1, 16, 40, 1'b1, 1'b1, 1'b0, 1'b1};
      vecs[5] = '{GoodDig, 3, 0,  5,  5, 0,  6, 13, 1'b1, 1'b0, 1'b1, 1'b0};

      bus.kmac_ready_i  = 1'b0;
      bus.kmac_done_i   = 1'b0;
      bus.kmac_digest_i = '0;
      @(negedge clk_i);
      do_reset(1'b1, "reset_state");

      for (int i = 0; i < 6; i++) run_vec(i, vecs[i]);

      // Reset while reading address 7, released two cycles later.
      do_reset(1'b0, "");
      bus.kmac_digest_i = GoodDig;
      bus.kmac_ready_i  = 1'b1;
      rst_ni = 1'b1;
      hit = 1'b0;
      for (int t = 0; t < Budget && !hit; t++) begin
         if (bus.rom_req_o && bus.rom_addr_o == AW'(7)) hit = 1'b1;
         else @(negedge clk_i);
      end
      check("rst_hit_addr7", 64'(hit), 64'd1);
      rst_ni = 1'b0;
      #1;
      check("rst_async_outs", outs(), 64'd0);
      @(negedge clk_i);
      check("rst_hold1_outs", outs(), 64'd0);
      @(negedge clk_i);
      check("rst_hold2_outs", outs(), 64'd0);
      rst_ni = 1'b1;
      check("rel_idle_outs", outs(), 64'd0);
      @(negedge clk_i);
      check("rel_first_req", 64'(bus.rom_req_o), 64'd1);
      check("rel_first_addr", 64'(bus.rom_addr_o), 64'd0);

`ifdef ROM_CTRL_CHECK_SEQ_BYPASS_EN
      bypass_i = 1'b1;
      do_reset(1'b0, "");
      rst_ni = 1'b1;
      t_done = -1;
      bad    = 0;
      for (int t = 0; t < 8; t++) begin
         if (bus.rom_req_o || bus.kmac_valid_o) bad++;
         if (check_done_o && t_done < 0) t_done = t;
         @(negedge clk_i);
      end
      check("byp_cycles", 64'(t_done + 1), 64'd2);
      check("byp_traffic", 64'(bad), 64'd0);
      check("byp_flags", {check_done_o, check_good_o, alert_o, sel_bus_o}, 4'b1101);
      bypass_i = 1'b0;
`else
      t_done = 0;
      bad    = 0;
`endif

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/rom_ctrl_check_seq.md
Name: rom_ctrl_check_seq

Overview:
- Sequences the power-up ROM integrity check.
- Walks ROM, streams the non-top words to KMAC over a valid/ready interface, and captures the top RomTopCount words as the expected digest.
- Waits for the KMAC digest, compares it with the expected digest, then hands ROM to the bus side.
- Sits between the ROM macro, the KMAC app interface and the ROM access mux select.

Parameters:
RomDepth, 16, number of ROM words; at least RomTopCount+2.
RomTopCount, 2, number of top words holding the expected digest; at least 1.
DW, 32, ROM data width and KMAC data word width.

Ports:
clk_i  in  1  clock
rst_ni  in  1  reset, asynchronous, active-low
rom_req_o  out  1  ROM read request
rom_addr_o  out  vbits(RomDepth)  ROM read address
rom_rdata_i  in  DW  ROM data, valid the cycle after rom_req_o; held until the next request
kmac_valid_o  out  1  data word valid to KMAC
kmac_data_o  out  DW  data word to KMAC
kmac_last_o  out  1  marks word RomNonTopCount-1
kmac_ready_i  in  1  KMAC accepts the word
kmac_done_i  in  1  single-cycle pulse: digest valid
kmac_digest_i  in  RomTopCount*DW  computed digest; word i in bits [i*DW +: DW]
sel_bus_o  out  1  1 = ROM mux gives access to the bus
check_done_o  out  1  check finished (level)
check_good_o  out  1  digest matched; meaningful only when check_done_o=1
alert_o  out  1  fatal alert (level)

Behaviour:
- Reset values: all outputs 0; state Idle; address 0; expected-digest register 0.
- Reset asserted mid-operation: immediate return to Idle, all outputs 0; the check restarts from address 0 after reset release.
- Idle -> ReadLow one cycle after reset release.
- ReadLow, request/data timing:
  - Entry cycle: rom_req_o=1, rom_addr_o=0.
  - Next cycle: data valid, so kmac_valid_o=1 and kmac_data_o=rom_rdata_i.
  - kmac_valid_o is held with stable data until kmac_ready_i=1.
  - kmac_last_o=1 while the word at address RomNonTopCount-1 is valid.
- ReadLow, handshake cycle (valid & ready):
  - If the word was not last: address increments, rom_req_o pulses with the new address, kmac_valid_o=0 the following cycle.
  - Steady-state throughput is one word per 2 cycles.
  - If the word was last: go to ReadHigh, request address RomNonTopCount.
- ReadHigh:
  - Reads addresses RomNonTopCount..RomDepth-1, one request every 2 cycles; kmac_valid_o=0 throughout.
  - Word k is stored in expected-digest word k-RomNonTopCount.
  - After the last word is stored, go to WaitKmac.
- WaitKmac: on kmac_done_i, latch kmac_digest_i and go to Compare.
- kmac_done_i in the same cycle the last top word is stored: the word is stored, the digest is latched, and the state goes directly to Compare.
- Compare, one cycle: match = (latched digest == expected digest), all RomTopCount*DW bits. Go to Done.
- Done (terminal until reset):
  - sel_bus_o=1, check_done_o=1, check_good_o=match.
  - alert_o=~match.
  - rom_req_o=0, kmac_valid_o=0.
- kmac_done_i seen in ReadLow or ReadHigh (early digest): go to Invalid.
- Invalid (terminal until reset):
  - alert_o=1, check_done_o=1, check_good_o=0.
  - sel_bus_o stays 0.
- Any unreachable state encoding: go to Invalid.
- Address arithmetic: width vbits(RomDepth); never increments past RomDepth-1.
- kmac_ready_i is ignored while kmac_valid_o=0.
- Total cycles from reset release to Done, with KMAC always ready and an immediate kmac_done_i: 1 + 2*RomDepth + 1 + 1.

Optional Feature:
- Macro: ROM_CTRL_CHECK_SEQ_BYPASS_EN.
- With the macro defined:
  - Adds input port bypass_i (1 bit), sampled in the first cycle after reset release.
  - If bypass_i=1, Idle goes directly to Done with check_good_o=1 and alert_o=0. No ROM or KMAC traffic occurs.
  - If bypass_i=0, behaviour is unchanged.
- Without the macro: the port is absent and the check always runs.

Decomposition:
- Package rom_ctrl_check_pkg holds:
  - state enum: Idle, ReadLow, ReadHigh, WaitKmac, Compare, Done, Invalid. Sparse 6-bit encoding with minimum Hamming distance 3.
  - localparam helper: RomNonTopCount = RomDepth - RomTopCount.
  - digest typedef: logic [RomTopCount*DW-1:0].
- One sub-module, rom_ctrl_digest_cmp:
  - Holds the expected-digest register with a word-indexed write port.
  - Holds the KMAC digest latch and the registered match output.

Test Plan:
- Default parameters, kmac_ready_i tied 1, ROM word n = 32'h1000+n, kmac_done_i 3 cycles after the last KMAC word, digest = {32'h100F, 32'h100E} -> exactly 14 KMAC words with data 32'h1000..32'h100D; kmac_last_o only on 32'h100D; Done with check_good_o=1, alert_o=0, sel_bus_o=1.
- Same setup, digest = {32'h100F, 32'h100F} -> check_good_o=0, alert_o=1, sel_bus_o=1.
- kmac_ready_i low for 5 cycles on word 3 -> kmac_valid_o stays 1 and kmac_data_o stays 32'h1003 for 5 cycles; no ROM request issued meanwhile.
- kmac_done_i pulsed while in ReadLow at address 5 -> Invalid next cycle: alert_o=1, check_done_o=1, check_good_o=0, sel_bus_o=0.
- rst_ni asserted at address 7 and released 2 cycles later -> all outputs 0 during reset; first request after release is at address 0.
- ROM_CTRL_CHECK_SEQ_BYPASS_EN defined, bypass_i=1 -> Done 2 cycles after reset release; no rom_req_o or kmac_valid_o ever; check_good_o=1.
